// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions.
// Provides the operand width and the state type of the bit-serial subtractor.
package arith_pkg;

    localparam int unsigned WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: d = x - y - bi, with borrow out.
// Ports:
//   x  - minuend bit
//   y  - subtrahend bit
//   bi - borrow in
//   d  - difference bit
//   bo - borrow out
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial 8-bit subtractor, D = a - b - bin, one bit per clock, LSB first.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset
//   start - request, accepted when ready=1
//   a, b  - minuend / subtrahend, sampled on the accepting edge
//   bin   - borrow in, sampled on the accepting edge
//   ready - idle or done, can accept start
//   done  - one-cycle pulse, results valid
//   D     - registered difference
//   bout  - borrow out of bit 7
//   ovf   - signed overflow
//   zero  - D == 0
module serial_subtractor_8bit
    import arith_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] D_q, D_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic             cell_d;
    logic             cell_bo;
    logic [WIDTH-1:0] res_next;

    full_subtractor u_fs (
        .x  (a_sh_q[0]),
        .y  (b_sh_q[0]),
        .bi (br_q),
        .d  (cell_d),
        .bo (cell_bo)
    );

    // New difference bit enters at the MSB; after 8 shifts bit 0 sits at the LSB.
    assign res_next = {cell_d, res_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            D_q     <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            br_q    <= br_d;
            D_q     <= D_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        br_d    = br_q;
        D_d     = D_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        case (state_q)
            S_RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = res_next;
                br_d   = cell_bo;
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    // br_q here is the borrow into bit 7.
                    D_d     = res_next;
                    bout_d  = cell_bo;
                    ovf_d   = br_q ^ cell_bo;
                    zero_d  = (res_next == '0);
                    state_d = S_DONE;
                end
            end
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ready = (state_q != S_RUN);
    assign done  = (state_q == S_DONE);
    assign D     = D_q;
    assign bout  = bout_q;
    assign ovf   = ovf_q;
    assign zero  = zero_q;

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
module tb_serial_subtractor_8bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a, b;
    logic       bin;
    logic       ready, done;
    logic [7:0] D;
    logic       bout, ovf, zero;

    int unsigned tests = 0;
    int unsigned fails = 0;

    always #5 clk = ~clk;

    serial_subtractor_8bit dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .ready (ready),
        .done  (done),
        .D     (D),
        .bout  (bout),
        .ovf   (ovf),
        .zero  (zero)
    );

    // Reference: unsigned/signed arithmetic straight from the definition.
    logic [7:0] exp_d;
    logic       exp_bout, exp_ovf, exp_zero;

    task automatic model(input logic [7:0] ma, input logic [7:0] mb, input logic mbin);
        int ua, ub, sr;
        ua = int'(ma);
        ub = int'(mb);
        exp_bout = (ua < ub + int'(mbin));
        exp_d    = 8'((ua - ub - int'(mbin)) & 255);
        sr       = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
        exp_ovf  = (sr < -128) || (sr > 127);
        exp_zero = (exp_d == 8'h00);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_result(input string tag);
        chk({tag, ".D"}, 32'(D), 32'(exp_d));
        chk({tag, ".bout"}, 32'(bout), 32'(exp_bout));
        chk({tag, ".ovf"}, 32'(ovf), 32'(exp_ovf));
        chk({tag, ".zero"}, 32'(zero), 32'(exp_zero));
    endtask

    // Called just after an accepting edge; counts edges until done is seen.
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!done && cyc < 20);
    endtask

    // Issue one operation from idle and check latency, result and pulse width.
    task automatic run_op(input string tag, input logic [7:0] oa, input logic [7:0] ob,
                          input logic obin, input logic check_timing);
        int cyc;
        @(negedge clk);
        start = 1'b1; a = oa; b = ob; bin = obin;
        @(posedge clk); #1;
        start = 1'b0;
        model(oa, ob, obin);
        wait_done(cyc);
        if (check_timing) begin
            chk({tag, ".latency"}, 32'(cyc), 32'd8);
            chk({tag, ".ready_in_done"}, 32'(ready), 32'd1);
        end else if (cyc != 8) begin
            chk({tag, ".latency"}, 32'(cyc), 32'd8);
        end
        chk_result(tag);
        @(posedge clk); #1;
        if (check_timing) chk({tag, ".done_width"}, 32'(done), 32'd0);
    endtask

    initial begin
        int cyc;
        int dones;
        logic [7:0] ra, rb;
        logic       rbin;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.ready", 32'(ready), 32'd1);
        chk("reset.done", 32'(done), 32'd0);
        chk("reset.D", 32'(D), 32'd0);
        chk("reset.bout", 32'(bout), 32'd0);
        chk("reset.ovf", 32'(ovf), 32'd0);
        chk("reset.zero", 32'(zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("t5m3", 8'h05, 8'h03, 1'b0, 1'b1);
        chk("t5m3.D_const", 32'(D), 32'h02);
        run_op("t0m1", 8'h00, 8'h01, 1'b0, 1'b1);
        chk("t0m1.D_const", 32'(D), 32'hFF);
        run_op("t80m1", 8'h80, 8'h01, 1'b0, 1'b1);
        chk("t80m1.ovf_const", 32'(ovf), 32'd1);
        run_op("t10m10b1", 8'h10, 8'h10, 1'b1, 1'b1);
        chk("t10m10b1.bout_const", 32'(bout), 32'd1);
        run_op("t10m10b0", 8'h10, 8'h10, 1'b0, 1'b1);
        chk("t10m10b0.zero_const", 32'(zero), 32'd1);

        // Start pulses during RUN must be ignored.
        @(negedge clk);
        start = 1'b1; a = 8'h3C; b = 8'h5A; bin = 1'b1;
        model(8'h3C, 8'h5A, 1'b1);
        @(posedge clk); #1;
        dones = 0;
        for (int i = 1; i <= 12; i++) begin
            // Pulse start with other operands on early RUN cycles only.
            if (i <= 6) begin
                start = (i % 2) == 1; a = 8'(i * 17); b = 8'(i * 3); bin = 1'b0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                dones++;
                chk("ignore.latency", 32'(i), 32'd8);
                chk_result("ignore");
            end
        end
        chk("ignore.done_count", 32'(dones), 32'd1);

        // Reset at edge E4 of an operation (previous result is nonzero).
        @(negedge clk);
        start = 1'b1; a = 8'h81; b = 8'h7F; bin = 1'b0;
        @(posedge clk); #1;   // E0
        start = 1'b0;
        repeat (3) @(posedge clk);   // E1..E3
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;   // E4
        chk("midrst.ready", 32'(ready), 32'd1);
        chk("midrst.done", 32'(done), 32'd0);
        chk("midrst.D", 32'(D), 32'd0);
        chk("midrst.bout", 32'(bout), 32'd0);
        chk("midrst.ovf", 32'(ovf), 32'd0);
        chk("midrst.zero", 32'(zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        chk("midrst.no_done", 32'(dones), 32'd0);
        run_op("after_rst", 8'h81, 8'h7F, 1'b0, 1'b1);

        // Back-to-back: start held high, operands changed during each DONE cycle.
        @(negedge clk);
        start = 1'b1; a = 8'h40; b = 8'hC0; bin = 1'b0;
        model(8'h40, 8'hC0, 1'b0);
        @(posedge clk); #1;
        wait_done(cyc);
        chk("b2b0.latency", 32'(cyc), 32'd8);
        chk_result("b2b0");
        a = 8'h01; b = 8'h02; bin = 1'b1;
        model(8'h01, 8'h02, 1'b1);
        wait_done(cyc);
        chk("b2b1.interval", 32'(cyc), 32'd9);
        chk_result("b2b1");
        a = 8'h7F; b = 8'hFF; bin = 1'b1;
        model(8'h7F, 8'hFF, 1'b1);
        wait_done(cyc);
        chk("b2b2.interval", 32'(cyc), 32'd9);
        chk_result("b2b2");
        start = 1'b0;
        @(posedge clk); #1;
        chk("b2b.stop_ready", 32'(ready), 32'd1);
        chk("b2b.stop_done", 32'(done), 32'd0);

        // Randomized vectors against the arithmetic reference.
        for (int i = 0; i < 1000; i++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rbin = 1'($urandom);
            run_op("rand", ra, rb, rbin, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_subtractor_8bit.md
# serial_subtractor_8bit

Bit-serial 8-bit subtractor computing D = a − b − bin, one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow. It is the subtraction counterpart to the 8-bit ripple-carry adder. It sits beside that adder in the arithmetic datapath and gives an area-minimal sequential alternative with a start/done handshake.

## Interface
Parameters:
- none (width fixed at 8)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; accepted only when ready=1
- a  input  8  minuend, sampled on the accepting edge
- b  input  8  subtrahend, sampled on the accepting edge
- bin  input  1  borrow-in, sampled on the accepting edge
- ready  output  1  block can accept start (IDLE or DONE)
- done  output  1  one-cycle pulse: D/bout/ovf/zero are valid
- D  output  8  difference, registered, held until the next completion
- bout  output  1  borrow out of bit 7
- ovf  output  1  signed (two's-complement) overflow
- zero  output  1  D == 8'h00

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: ready=1, done=0. On start=1, capture a, b and bin into shift registers, clear bit counter cnt[2:0] to 0, and go to RUN.
- RUN: ready=0. Each edge, the cell computes d_i = a_i ^ b_i ^ br and br' = (~a_i & b_i) | (~(a_i ^ b_i) & br).
  - d_i shifts into the result register MSB-side; operands shift right; br updates; cnt increments.
- RUN exit: on the edge where cnt==7, load D, bout=br', ovf and zero; go to DONE.
- ovf = borrow into bit 7 XOR borrow out of bit 7. Capture br before the bit-7 step.
- DONE: done=1 and ready=1 for exactly one cycle.
  - start=1 in DONE is accepted exactly as in IDLE and goes straight to RUN.
  - Otherwise the FSM returns to IDLE.
- start is ignored while in RUN; it is not queued.
- Outputs D/bout/ovf/zero change only on the RUN→DONE edge and on reset.
- Arithmetic is modulo 2^8. bout=1 iff a < b + bin as unsigned values.

## Timing
- Reset values: ready=1, done=0, D=8'h00, bout=0, ovf=0, zero=0; FSM=IDLE, cnt=0, borrow register=0.
- Reset mid-operation: the current operation is abandoned, no done is emitted, and all outputs take their reset values on the next edge.
- Latency: start is accepted at edge E0, bits 0..7 are processed at edges E1..E8, and done is high between E8 and E9.
- Throughput: one operation per 9 cycles with back-to-back starts (start held high in DONE).
- rst has priority over start on the same edge.

## Structure
- Shared package arith_pkg:
  - WIDTH=8
  - state encoding localparams S_IDLE, S_RUN, S_DONE
- One sub-module: full_subtractor (inputs x, y, bi; outputs d, bo; purely combinational), instantiated once.
- Top-level holds the FSM, cnt, operand shift registers, borrow flip-flop and output registers.

## Test plan
- a=8'h05, b=8'h03, bin=0 → D=8'h02, bout=0, ovf=0, zero=0; done 8 edges after start, for exactly 1 cycle.
- a=8'h00, b=8'h01, bin=0 → D=8'hFF, bout=1, ovf=0. Then a=8'h80, b=8'h01 → D=8'h7F, bout=0, ovf=1.
- a=8'h10, b=8'h10, bin=1 → D=8'hFF, bout=1. Then a=8'h10, b=8'h10, bin=0 → D=8'h00, zero=1.
- Start pulses during RUN with different operands → ignored; result matches the first operands, and exactly one done pulse.
- rst asserted for 1 cycle at edge E4 of an operation → no done, all outputs at reset values, ready=1. A new start afterwards completes correctly.
- start held high continuously with 3 operand sets changed on each DONE cycle → three done pulses 9 cycles apart, each result correct. Random 1000-vector compare against a − b − bin.
